world_map_arbiter: RTL and testbench
====================================

// Module: world_map_arbiter
// PURPOSE
//   Shares the single-port world-map RAM between two requesters: the VGA pixel fetch
//   (pixel_row/pixel_column from the display timing generator; result drives world_pixel
//   into the colorizer) and the bot/CPU side (map reads/writes for LocX/LocY updates).
//   Video has priority; the CPU is served in free slots, with starvation protection.
//   Sits between vga_subsystem and the map BRAM, in the sys_clk domain.
// PARAMETERS
//   MAP_W       128  map width in cells; power of two
//   MAP_H       128  map height in cells
//   CELL_SHIFT  2    log2(display pixels per cell edge); cell = pixel >> CELL_SHIFT
//   ADDR_W      14   RAM address width; equals log2(MAP_W) + log2(MAP_H)
//   STARVE_MAX  8    CPU wait cycles before the CPU wins one issue point over video
// PORTS
//   sys_clk     in   1       system clock; all logic on the rising edge
//   sys_rst     in   1       synchronous reset, active-low
//   vid_req     in   1       one-cycle pulse: fetch the cell under vid_row/vid_col
//   vid_row     in   10      display pixel row
//   vid_col     in   10      display pixel column
//   vid_pixel   out  2       fetched cell value (world_pixel)
//   vid_valid   out  1       one-cycle pulse: vid_pixel updated
//   vid_overrun out  1       sticky: a vid_req arrived while one was already pending
//   cpu_req     in   1       CPU request; held with addr/we/wdata stable until cpu_ack
//   cpu_we      in   1       1 = write, 0 = read
//   cpu_addr    in   ADDR_W  cell address = {y, x}
//   cpu_wdata   in   2       write data
//   cpu_rdata   out  2       read data; valid while cpu_ack = 1
//   cpu_ack     out  1       one-cycle completion pulse
//   cpu_starve  out  1       sticky: the starvation override has fired at least once
//   mem_en      out  1       RAM enable (registered)
//   mem_we      out  1       RAM write enable (registered)
//   mem_addr    out  ADDR_W  RAM address (registered)
//   mem_wdata   out  2       RAM write data (registered)
//   mem_rdata   in   2       RAM read data; 1-cycle synchronous read
// BEHAVIOUR
//   - Reset (sys_rst = 0 at an edge): state = IDLE. Clear all pending and sticky flags and
//     the wait counter. All outputs = 0.
//     * Mid-operation reset aborts the operation. No ack or valid is issued for it.
//       The CPU must re-request.
//   - Pending flags:
//     * vid_req sets vid_pend and latches row/col. If vid_pend is already set: the new
//       coordinates replace the old ones and vid_overrun is set.
//     * cpu_req is a level; it is pending until cpu_ack.
//   - FSM: IDLE -> {VID_WAIT | CPU_WAIT} -> {VID_DATA | CPU_DATA} -> IDLE or next issue.
//     * Issue points: IDLE, VID_DATA, CPU_DATA.
//       At an issue point the FSM registers mem_* and enters the matching *_WAIT state.
//     * A vid_req arriving in the same cycle as an issue point is eligible for that issue.
//     * Back-to-back ops: one op every 2 cycles.
//   - Priority: video first, unless cpu_wait_cnt >= STARVE_MAX. In that case the CPU wins
//     that one issue point, cpu_starve is set, and the counter clears.
//     * cpu_wait_cnt counts cycles with cpu_req = 1 and no grant. Saturates; clears on grant.
//   - Video address mapping:
//     * cy = vid_row >> CELL_SHIFT, cx = vid_col >> CELL_SHIFT.
//     * addr = {cy[log2 MAP_H-1:0], cx[log2 MAP_W-1:0]}.
//     * Out of map (cx >= MAP_W or cy >= MAP_H): slot still consumed, mem_en = 0,
//       vid_pixel = 2'b00.
//   - Latency: issue at edge E0 (RAM sees the address at E1). At E2, capture mem_rdata:
//     * video: vid_pixel <= data, vid_valid = 1 for one cycle.
//     * CPU: cpu_rdata <= data, cpu_ack = 1 for one cycle. Writes ack at the same E2,
//       cpu_rdata = 0.
//     * Uncontended vid_req to vid_valid: 2 cycles.
//   - mem_en and mem_we are high only in the cycle after the issue edge.
//     vid_pixel holds its value between fetches.
//   - cpu_req dropped before ack: treated as still pending until ack. This is a protocol
//     violation, not checked.
// TESTING
//   - Reset, then one vid_req at row 8, col 12: mem_addr = {7'd2, 7'd3} = 259.
//     RAM[259] = 2'b10 -> vid_valid 2 cycles later with vid_pixel = 2'b10.
//   - vid_req at row 0, col 600 (cx = 150 >= 128): mem_en stays 0;
//     vid_valid after 2 cycles with vid_pixel = 2'b00.
//   - CPU write addr 5, data 2'b11, then CPU read addr 5: each acked 2 cycles after issue;
//     the read returns cpu_rdata = 2'b11.
//   - vid_req every 2 cycles with cpu_req held: after 8 wait cycles the CPU is granted
//     and cpu_starve = 1. Video resumes on the next issue point. Check for vid_overrun
//     if a pend was replaced.
//   - vid_req and cpu_req in the same IDLE cycle: video issued first; CPU issued at
//     VID_DATA; cpu_ack 2 cycles after vid_valid.
//   - sys_rst = 0 during CPU_WAIT: no cpu_ack; all outputs and flags = 0 the next cycle.

Source files
------------

// File: rtl/world_map_arbiter_if.sv
// Bundles the video, CPU and map-RAM signals that pass through the world-map arbiter.
// Latency: none; this is wiring only.
// Backpressure: none; the CPU side holds its request level until cpu_ack.
interface world_map_arbiter_if #(
    parameter int ADDR_W = 14
);
    // video fetch side
    logic              vid_req;
    logic [9:0]        vid_row;
    logic [9:0]        vid_col;
    logic [1:0]        vid_pixel;
    logic              vid_valid;
    logic              vid_overrun;
    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [1:0]        cpu_wdata;
    logic [1:0]        cpu_rdata;
    logic              cpu_ack;
    logic              cpu_starve;
    // map RAM side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_wdata;
    logic [1:0]        mem_rdata;

    // arbiter view
    modport slave (
        input  vid_req, vid_row, vid_col,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output vid_pixel, vid_valid, vid_overrun,
        output cpu_rdata, cpu_ack, cpu_starve,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // requester / RAM-model view
    modport master (
        output vid_req, vid_row, vid_col,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  vid_pixel, vid_valid, vid_overrun,
        input  cpu_rdata, cpu_ack, cpu_starve,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/world_map_arbiter.sv
// Shares the single-port world-map RAM between video pixel fetch (priority) and the CPU.
// Latency: issue edge to vid_valid / cpu_ack is 2 cycles; one RAM op every 2 cycles.
// Backpressure: CPU holds cpu_req until cpu_ack; video waits in a 1-deep pend (overwritten on overrun).
module world_map_arbiter #(
    parameter int MAP_W      = 128,
    parameter int MAP_H      = 128,
    parameter int CELL_SHIFT = 2,
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    world_map_arbiter_if.slave   bus
);

    localparam int XW    = $clog2(MAP_W);
    localparam int YW    = $clog2(MAP_H);
    localparam int CW    = 10 - CELL_SHIFT;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        VID_WAIT,
        VID_DATA,
        CPU_WAIT,
        CPU_DATA
    } state_t;

    state_t            state;
    logic              vid_pend;
    logic [9:0]        vid_row_q;
    logic [9:0]        vid_col_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              op_oom;
    logic              op_we;

    logic [9:0]        eff_row;
    logic [9:0]        eff_col;
    logic [CW-1:0]     cy;
    logic [CW-1:0]     cx;
    logic              vid_oom;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_elig;
    logic              cpu_elig;
    logic              issue_pt;
    logic              starve_win;
    logic              grant_cpu;
    logic              grant_vid;

    // Arbitration: a same-cycle vid_req overrides the latched coordinates; the CPU
    // request being acked in CPU_DATA is not eligible again at that same issue point.
    always_comb begin
        eff_row    = bus.vid_req ? bus.vid_row : vid_row_q;
        eff_col    = bus.vid_req ? bus.vid_col : vid_col_q;
        cy         = CW'(eff_row >> CELL_SHIFT);
        cx         = CW'(eff_col >> CELL_SHIFT);
        vid_oom    = (32'(cx) >= MAP_W) || (32'(cy) >= MAP_H);
        vid_addr   = ADDR_W'({cy[YW-1:0], cx[XW-1:0]});
        vid_elig   = bus.vid_req || vid_pend;
        cpu_elig   = bus.cpu_req && (state != CPU_WAIT) && (state != CPU_DATA);
        issue_pt   = (state == IDLE) || (state == VID_DATA) || (state == CPU_DATA);
        starve_win = cpu_elig && (32'(wait_cnt) >= STARVE_MAX);
        grant_cpu  = issue_pt && cpu_elig && (!vid_elig || starve_win);
        grant_vid  = issue_pt && vid_elig && !grant_cpu;
    end

    // Single FSM: pend/starvation bookkeeping, data capture, and registered RAM issue.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state           <= IDLE;
            vid_pend        <= 1'b0;
            vid_row_q       <= '0;
            vid_col_q       <= '0;
            wait_cnt        <= '0;
            op_oom          <= 1'b0;
            op_we           <= 1'b0;
            bus.vid_pixel   <= 2'b00;
            bus.vid_valid   <= 1'b0;
            bus.vid_overrun <= 1'b0;
            bus.cpu_rdata   <= 2'b00;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_starve  <= 1'b0;
            bus.mem_en      <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= 2'b00;
        end else begin
            bus.vid_valid <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;

            if (bus.vid_req) begin
                vid_row_q <= bus.vid_row;
                vid_col_q <= bus.vid_col;
                if (vid_pend) begin
                    bus.vid_overrun <= 1'b1;
                end
            end
            vid_pend <= vid_elig && !grant_vid;

            if (grant_cpu) begin
                wait_cnt <= '0;
            end else if (cpu_elig && (32'(wait_cnt) < STARVE_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            case (state)
                VID_WAIT: state <= VID_DATA;
                CPU_WAIT: state <= CPU_DATA;
                VID_DATA: begin
                    bus.vid_pixel <= op_oom ? 2'b00 : bus.mem_rdata;
                    bus.vid_valid <= 1'b1;
                end
                CPU_DATA: begin
                    bus.cpu_rdata <= op_we ? 2'b00 : bus.mem_rdata;
                    bus.cpu_ack   <= 1'b1;
                end
                default: ;
            endcase

            if (issue_pt) begin
                if (grant_cpu) begin
                    bus.mem_en    <= 1'b1;
                    bus.mem_we    <= bus.cpu_we;
                    bus.mem_addr  <= bus.cpu_addr;
                    bus.mem_wdata <= bus.cpu_wdata;
                    op_we         <= bus.cpu_we;
                    if (starve_win && vid_elig) begin
                        bus.cpu_starve <= 1'b1;
                    end
                    state <= CPU_WAIT;
                end else if (grant_vid) begin
                    // an out-of-map fetch still burns the slot but never touches the RAM
                    bus.mem_en    <= !vid_oom;
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= vid_addr;
                    bus.mem_wdata <= 2'b00;
                    op_oom        <= vid_oom;
                    state         <= VID_WAIT;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_world_map_arbiter.sv
// Self-checking bench for world_map_arbiter with a behavioural map RAM and scoreboard queues.
// Latency: expected results are popped one cycle-sample after each vid_valid / cpu_ack.
// Backpressure: CPU requests are held until the ack is seen, as the real requester would.
module tb_world_map_arbiter;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    world_map_arbiter_if #(.ADDR_W(14)) bus ();

    world_map_arbiter #(
        .MAP_W(128), .MAP_H(128), .CELL_SHIFT(2), .ADDR_W(14), .STARVE_MAX(8)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vid_cnt  = 0;
    int cpu_cnt  = 0;
    int vid_cyc  = -100;
    int cpu_cyc  = -100;
    logic [1:0] vid_q[$];
    logic [1:0] cpu_q[$];
    logic [1:0] ram[int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // initial map contents for cells never written by the CPU
    function automatic logic [1:0] pat(input int a);
        if (a == 259) return 2'b10;
        if (a == 22)  return 2'b01;
        return 2'(a & 3) ^ 2'((a >> 3) & 3);
    endfunction

    // single-port RAM, one-cycle synchronous read
    always @(posedge sys_clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wdata;
            else bus.mem_rdata <= ram.exists(int'(bus.mem_addr)) ? ram[int'(bus.mem_addr)]
                                                                 : pat(int'(bus.mem_addr));
        end
    end

    // monitor: cycle count plus scoreboard pops on completion pulses
    always begin
        @(posedge sys_clk);
        #1;
        cyc++;
        if (bus.vid_valid) begin
            vid_cnt++;
            vid_cyc = cyc;
            if (vid_q.size() == 0) check("vid_unexpected", 1, 0);
            else check("vid_pixel", 32'(bus.vid_pixel), 32'(vid_q.pop_front()));
        end
        if (bus.cpu_ack) begin
            cpu_cnt++;
            cpu_cyc = cyc;
            if (cpu_q.size() == 0) check("cpu_unexpected", 1, 0);
            else check("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_zero(input string tag);
        check({tag, "_vid_pixel"},   32'(bus.vid_pixel),   0);
        check({tag, "_vid_valid"},   32'(bus.vid_valid),   0);
        check({tag, "_vid_overrun"}, 32'(bus.vid_overrun), 0);
        check({tag, "_cpu_rdata"},   32'(bus.cpu_rdata),   0);
        check({tag, "_cpu_ack"},     32'(bus.cpu_ack),     0);
        check({tag, "_cpu_starve"},  32'(bus.cpu_starve),  0);
        check({tag, "_mem_en"},      32'(bus.mem_en),      0);
        check({tag, "_mem_we"},      32'(bus.mem_we),      0);
        check({tag, "_mem_addr"},    32'(bus.mem_addr),    0);
        check({tag, "_mem_wdata"},   32'(bus.mem_wdata),   0);
    endtask

    task automatic wait_vid(input int c0);
        int n = 0;
        while (vid_cnt == c0 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        if (vid_cnt == c0) check("vid_timeout", 0, 1);
    endtask

    task automatic wait_cpu(input int c0);
        int n = 0;
        while (cpu_cnt == c0 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        bus.cpu_req = 1'b0;
        if (cpu_cnt == c0) check("cpu_timeout", 0, 1);
    endtask

    task automatic vid_fetch(input string tag, input int row, input int col,
                             input logic [1:0] exp_pix, input logic exp_en, input int exp_addr);
        int c0 = vid_cnt;
        int t;
        vid_q.push_back(exp_pix);
        bus.vid_req = 1'b1;
        bus.vid_row = 10'(row);
        bus.vid_col = 10'(col);
        @(negedge sys_clk);
        bus.vid_req = 1'b0;
        t = cyc;
        check({tag, "_mem_en"}, 32'(bus.mem_en), 32'(exp_en));
        if (exp_en) check({tag, "_mem_addr"}, 32'(bus.mem_addr), exp_addr);
        @(negedge sys_clk);
        check({tag, "_mem_en_pulse"}, 32'(bus.mem_en), 0);
        wait_vid(c0);
        check({tag, "_latency"}, vid_cyc - t, 2);
        @(negedge sys_clk);
        check({tag, "_hold"}, 32'(bus.vid_pixel), 32'(exp_pix));
    endtask

    task automatic cpu_op(input string tag, input logic we, input int addr,
                          input logic [1:0] wd, input logic [1:0] exp);
        int c0 = cpu_cnt;
        int t;
        cpu_q.push_back(exp);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = 14'(addr);
        bus.cpu_wdata = wd;
        @(negedge sys_clk);
        t = cyc;
        check({tag, "_mem_en"},   32'(bus.mem_en),   1);
        check({tag, "_mem_we"},   32'(bus.mem_we),   32'(we));
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), addr);
        if (we) check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(wd));
        wait_cpu(c0);
        check({tag, "_latency"}, cpu_cyc - t, 2);
        @(negedge sys_clk);
    endtask

    initial begin
        int t, ts, cv0, cc0, a;
        bus.vid_req = 1'b0; bus.vid_row = '0; bus.vid_col = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        repeat (3) @(negedge sys_clk);
        check_zero("reset");
        sys_rst = 1'b1;
        @(negedge sys_clk);

        // in-map fetch and out-of-map fetch
        vid_fetch("vid_in_map", 8, 12, 2'b10, 1'b1, 259);
        vid_fetch("vid_oom", 0, 600, 2'b00, 1'b0, 0);

        // CPU write then read back
        cpu_op("cpu_wr", 1'b1, 5, 2'b11, 2'b00);
        cpu_op("cpu_rd", 1'b0, 5, 2'b00, 2'b11);

        // simultaneous video and CPU in IDLE: video first, CPU at VID_DATA
        cv0 = vid_cnt; cc0 = cpu_cnt;
        a = 3 * 128 + 7;
        vid_q.push_back(pat(a));
        cpu_q.push_back(2'b11);
        bus.vid_req = 1'b1; bus.vid_row = 10'd12; bus.vid_col = 10'd28;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd5;
        @(negedge sys_clk);
        bus.vid_req = 1'b0;
        t = cyc;
        wait_cpu(cc0);
        check("same_vid_count", vid_cnt - cv0, 1);
        check("same_vid_lat", vid_cyc - t, 2);
        check("same_cpu_lat", cpu_cyc - t, 4);
        repeat (2) @(negedge sys_clk);

        // continuous video with CPU held: starvation override at the 5th issue point
        cv0 = vid_cnt; cc0 = cpu_cnt;
        cpu_q.push_back(2'b11);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd5;
        ts = cyc + 1;
        for (int i = 0; i < 14; i++) begin
            if (cpu_cnt != cc0) bus.cpu_req = 1'b0;
            if (i % 2 == 0) begin
                bus.vid_req = 1'b1;
                bus.vid_row = 10'(4 * (i / 2 + 3));
                bus.vid_col = 10'(4 * (i + 5));
                // the fetch requested at i==8 is superseded while pending
                if (i != 8) vid_q.push_back(pat((i / 2 + 3) * 128 + (i + 5)));
            end else begin
                bus.vid_req = 1'b0;
            end
            if (i == 9) begin
                check("starve_set", 32'(bus.cpu_starve), 1);
                check("overrun_early", 32'(bus.vid_overrun), 0);
            end
            @(negedge sys_clk);
        end
        bus.vid_req = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("starve_ack_cycle", cpu_cyc - ts, 10);
        check("starve_cpu_count", cpu_cnt - cc0, 1);
        check("starve_vid_count", vid_cnt - cv0, 6);
        check("starve_sticky", 32'(bus.cpu_starve), 1);
        check("overrun_sticky", 32'(bus.vid_overrun), 1);

        // reset while the CPU read sits in CPU_WAIT
        cc0 = cpu_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd9;
        @(negedge sys_clk);
        check("midrst_issued", 32'(bus.mem_en), 1);
        sys_rst = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge sys_clk);
        check_zero("midrst");
        sys_rst = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("midrst_no_ack", cpu_cnt - cc0, 0);

        check("vid_q_drained", vid_q.size(), 0);
        check("cpu_q_drained", cpu_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
